// File: rtl/util_startup_spi_if.sv
// Request and read-data stream channels of the STARTUP SPI flash reader.
// master = requester/consumer, slave = flash controller.
interface util_startup_spi_if #(
  parameter int LEN_WIDTH = 16
);
  logic                 req_valid;
  logic                 req_ready;
  logic [23:0]          req_addr;
  logic [LEN_WIDTH-1:0] req_len;
  logic [7:0]           m_data;
  logic                 m_valid;
  logic                 m_ready;

  modport master (
    output req_valid, req_addr, req_len, m_ready,
    input  req_ready, m_data, m_valid
  );

  modport slave (
    input  req_valid, req_addr, req_len, m_ready,
    output req_ready, m_data, m_valid
  );
endinterface

// File: rtl/util_startup_spi.sv
// Single-lane (mode 0) SPI flash read controller on the STARTUP user pins:
// waits for EOS, primes the flash, then serves 0x03 reads as a byte stream.
module util_startup_spi #(
  parameter int C_CLK_DIV    = 2,
  parameter int C_LEN_WIDTH  = 16,
  parameter int C_PRIME_CLKS = 3,
  parameter int C_CS_HIGH    = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                eos,
  util_startup_spi_if.slave   bus,
  output logic                busy,
  output logic                usrcclko,
  output logic                usrcclkts,
  output logic                fcsbo,
  output logic                fcsbts,
  output logic [3:0]          dout,   // STARTUP DO pins ("do" is a reserved word)
  output logic [3:0]          dts,
  input  logic [3:0]          di
);

  localparam int DW = (C_CLK_DIV > 1)    ? $clog2(C_CLK_DIV)    : 1;
  localparam int PW = (C_PRIME_CLKS > 1) ? $clog2(C_PRIME_CLKS) : 1;
  localparam int CW = (C_CS_HIGH > 1)    ? $clog2(C_CS_HIGH)    : 1;

  typedef enum logic [2:0] {
    WAIT_EOS, PRIME, IDLE, CMD, ADDR, DATA, STALL, DESEL
  } state_t;

  state_t                 state_reg;
  logic [1:0]             eos_sync_reg;
  logic [DW-1:0]          div_cnt_reg;
  logic                   sck_reg;
  logic                   cs_n_reg;
  logic                   mosi_reg;
  logic [31:0]            sr_reg;
  logic [4:0]             bit_cnt_reg;
  logic [PW-1:0]          prime_cnt_reg;
  logic [CW-1:0]          cs_cnt_reg;
  logic [C_LEN_WIDTH-1:0] len_reg;
  logic [6:0]             rx_reg;
  logic [7:0]             m_data_reg;
  logic                   m_valid_reg;

  logic sck_run, tick, rise, fall, accept;
  logic di_unused;

  assign sck_run = (state_reg == PRIME) || (state_reg == CMD) ||
                   (state_reg == ADDR)  || (state_reg == DATA);
  assign tick    = sck_run && (div_cnt_reg == DW'(C_CLK_DIV - 1));
  assign rise    = tick && !sck_reg;
  assign fall    = tick && sck_reg;
  assign accept  = bus.req_valid && bus.req_ready;

  // A new request waits for any byte still pending from the previous one.
  assign bus.req_ready = (state_reg == IDLE) && !m_valid_reg;
  assign bus.m_data    = m_data_reg;
  assign bus.m_valid   = m_valid_reg;
  assign busy          = (state_reg != IDLE);

  // DQ0 = MOSI, DQ1 = MISO (hi-Z), DQ2 = WP#, DQ3 = HOLD#
  assign usrcclko  = sck_reg;
  assign usrcclkts = 1'b0;
  assign fcsbo     = cs_n_reg;
  assign fcsbts    = 1'b0;
  assign dout      = {2'b11, 1'b0, mosi_reg};
  assign dts       = 4'b0010;
  assign di_unused = ^{di[3:2], di[0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= WAIT_EOS;
      eos_sync_reg  <= 2'b00;
      div_cnt_reg   <= '0;
      sck_reg       <= 1'b0;
      cs_n_reg      <= 1'b1;
      mosi_reg      <= 1'b0;
      sr_reg        <= '0;
      bit_cnt_reg   <= '0;
      prime_cnt_reg <= '0;
      cs_cnt_reg    <= '0;
      len_reg       <= '0;
      rx_reg        <= '0;
      m_data_reg    <= '0;
      m_valid_reg   <= 1'b0;
    end else begin
      eos_sync_reg <= {eos_sync_reg[0], eos};

      // SCK divider; held at zero with SCK low whenever the clock is stopped
      if (sck_run) begin
        if (tick) begin
          div_cnt_reg <= '0;
          sck_reg     <= ~sck_reg;
        end else begin
          div_cnt_reg <= div_cnt_reg + DW'(1);
        end
      end else begin
        div_cnt_reg <= '0;
        sck_reg     <= 1'b0;
      end

      if (m_valid_reg && bus.m_ready) begin
        m_valid_reg <= 1'b0;
      end

      case (state_reg)
        WAIT_EOS: begin
          if (eos_sync_reg[1]) begin
            prime_cnt_reg <= '0;
            state_reg     <= PRIME;
          end
        end
        PRIME: begin
          if (fall) begin
            prime_cnt_reg <= prime_cnt_reg + PW'(1);
            if (prime_cnt_reg == PW'(C_PRIME_CLKS - 1)) begin
              state_reg <= IDLE;
            end
          end
        end
        IDLE: begin
          if (accept && (bus.req_len != '0)) begin
            sr_reg      <= {8'h03, bus.req_addr};
            mosi_reg    <= 1'b0;  // MSB of the 0x03 opcode
            len_reg     <= bus.req_len;
            bit_cnt_reg <= '0;
            cs_n_reg    <= 1'b0;
            state_reg   <= CMD;
          end
        end
        CMD, ADDR: begin
          if (fall) begin
            sr_reg   <= {sr_reg[30:0], 1'b0};
            mosi_reg <= sr_reg[30];
            if ((state_reg == CMD) && (bit_cnt_reg == 5'd7)) begin
              bit_cnt_reg <= '0;
              state_reg   <= ADDR;
            end else if ((state_reg == ADDR) && (bit_cnt_reg == 5'd23)) begin
              bit_cnt_reg <= '0;
              state_reg   <= DATA;
            end else begin
              bit_cnt_reg <= bit_cnt_reg + 5'd1;
            end
          end
        end
        DATA: begin
          if (rise) begin
            rx_reg <= {rx_reg[5:0], di[1]};
            if (bit_cnt_reg == 5'd7) begin
              m_data_reg  <= {rx_reg, di[1]};
              m_valid_reg <= 1'b1;
            end
          end
          if (fall) begin
            if (bit_cnt_reg == 5'd7) begin
              bit_cnt_reg <= '0;
              len_reg     <= len_reg - C_LEN_WIDTH'(1);
              if (len_reg == C_LEN_WIDTH'(1)) begin
                cs_n_reg   <= 1'b1;
                cs_cnt_reg <= '0;
                state_reg  <= DESEL;
              end else if (m_valid_reg && !bus.m_ready) begin
                // next byte would have nowhere to go: park between bytes
                state_reg <= STALL;
              end
            end else begin
              bit_cnt_reg <= bit_cnt_reg + 5'd1;
            end
          end
        end
        STALL: begin
          if (!m_valid_reg || bus.m_ready) begin
            state_reg <= DATA;
          end
        end
        DESEL: begin
          if (cs_cnt_reg == CW'(C_CS_HIGH - 1)) begin
            state_reg <= IDLE;
          end else begin
            cs_cnt_reg <= cs_cnt_reg + CW'(1);
          end
        end
        default: state_reg <= WAIT_EOS;
      endcase
    end
  end

endmodule

// File: tb/tb_util_startup_spi.sv
// Bench for util_startup_spi: behavioural SPI flash on the pins plus a byte
// scoreboard filled at request time and drained as the stream is consumed.
module tb_util_startup_spi;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       eos = 1'b0;
  logic       busy, usrcclko, usrcclkts, fcsbo, fcsbts;
  logic [3:0] dout, dts, di;

  util_startup_spi_if #(.LEN_WIDTH(16)) bus ();

  util_startup_spi #(
    .C_CLK_DIV(2), .C_LEN_WIDTH(16), .C_PRIME_CLKS(3), .C_CS_HIGH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .eos(eos), .bus(bus), .busy(busy),
    .usrcclko(usrcclko), .usrcclkts(usrcclkts), .fcsbo(fcsbo),
    .fcsbts(fcsbts), .dout(dout), .dts(dts), .di(di)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q[$];

  function automatic logic [7:0] flash_byte(input logic [23:0] a);
    if (a == 24'h123456) return 8'hA5;
    if (a == 24'h123457) return 8'h3C;
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
  endfunction

  // flash model: shifts in cmd+addr on SCK rise, drives MISO on SCK fall
  int          fl_bits = 0;
  logic [31:0] fl_shift = '0;
  int          cs_pulses = 0;
  int          prime_pulses = 0;
  int          fl_k;
  logic [7:0]  fl_b;

  always @(posedge usrcclko or posedge fcsbo) begin
    if (fcsbo) begin
      fl_bits <= 0;
      if (usrcclko) prime_pulses <= prime_pulses + 1;
    end else begin
      cs_pulses <= cs_pulses + 1;
      if (fl_bits < 32) fl_shift <= {fl_shift[30:0], dout[0]};
      fl_bits <= fl_bits + 1;
    end
  end

  always @(negedge usrcclko) begin
    if (!fcsbo && fl_bits >= 32) begin
      fl_k = fl_bits - 32;
      fl_b = flash_byte(fl_shift[23:0] + 24'(fl_k / 8));
      di <= {2'b00, fl_b[7 - (fl_k % 8)], 1'b0};
    end
  end

  task automatic do_req(input logic [23:0] a, input logic [15:0] l);
    bit ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.req_ready === 1'b1) begin ok = 1; break; end
    end
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL req_ready_wait: req_ready=%b required 1", bus.req_ready);
      return;
    end
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    bus.req_len   = l;
    for (int i = 0; i < int'(l); i++) exp_q.push_back(flash_byte(a + 24'(i)));
    @(negedge clk);
    bus.req_valid = 1'b0;
    tests++;
    if (fcsbo !== (l == 0)) begin
      fails++;
      $display("FAIL cs_after_accept: fcsbo=%b required %b", fcsbo, (l == 0));
    end
    $display("[TB] request addr=%h len=%0d", a, l);
  endtask

  task automatic drain(input int hold, input bit rnd, output int hi_run);
    int cyc = 0, got = 0, held = 0, p0 = 0, p1 = 0;
    bit hold_bad = 0, holding;
    logic [7:0] e;
    hi_run = 0;
    while (cyc < 5000 && (exp_q.size() != 0 || busy || bus.m_valid)) begin
      @(negedge clk);
      cyc++;
      hi_run = fcsbo ? hi_run + 1 : 0;
      holding = (hold > 0) && (got == 0) && bus.m_valid && (held < hold);
      if (holding) begin
        if (held == 0) p0 = cs_pulses;
        else if (fcsbo !== 1'b0 || exp_q.size() == 0 || bus.m_data !== exp_q[0]) hold_bad = 1;
        if (held == hold - 1) p1 = cs_pulses;
        held++;
        bus.m_ready = 1'b0;
      end else begin
        bus.m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (bus.m_valid && bus.m_ready) begin
        tests++;
        got++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL extra_byte: m_data=%h required no byte", bus.m_data);
        end else begin
          e = exp_q.pop_front();
          if (bus.m_data !== e) begin
            fails++;
            $display("FAIL data_byte: m_data=%h required %h", bus.m_data, e);
          end else $display("[TB] byte %h ok", e);
        end
      end
    end
    bus.m_ready = 1'b1;
    tests++;
    if (cyc >= 5000) begin
      fails++;
      $display("FAIL drain_timeout: %0d bytes left, busy=%b", exp_q.size(), busy);
    end
    if (hold > 0) begin
      tests++;
      if (held != hold || hold_bad || p1 != p0) begin
        fails++;
        $display("FAIL stall_hold: held=%0d bad=%b sck_edges=%0d required %0d/0/0",
                 held, hold_bad, p1 - p0, hold);
      end
    end
  endtask

  task automatic check_pulses(input string nm, input int got, input int req);
    tests++;
    if (got != req) begin
      fails++;
      $display("FAIL %s: pulses=%0d required %0d", nm, got, req);
    end else $display("[TB] %s %0d pulses ok", nm, got);
  endtask

  task automatic wait_ready_after_prime(input string nm);
    int p0 = prime_pulses, hi = 0;
    bit ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (usrcclko) hi++;
      if (bus.req_ready === 1'b1) begin ok = 1; break; end
    end
    tests++;
    if (!ok || prime_pulses - p0 != 3 || hi != 6) begin
      fails++;
      $display("FAIL %s: ready=%b prime=%0d sck_high_clks=%0d required 1/3/6",
               nm, ok, prime_pulses - p0, hi);
    end else $display("[TB] %s priming ok", nm);
  endtask

  task automatic test_reset();
    int p0;
    bit bad = 0;
    repeat (3) @(negedge clk);
    tests++;
    if (fcsbo !== 1'b1 || usrcclko !== 1'b0 || dout !== 4'b1100 || dts !== 4'b0010) begin
      fails++;
      $display("FAIL reset_pins: cs=%b sck=%b do=%b dts=%b required 1/0/1100/0010",
               fcsbo, usrcclko, dout, dts);
    end
    tests++;
    if (bus.m_valid !== 1'b0 || bus.m_data !== 8'h00 || bus.req_ready !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL reset_ctrl: mv=%b md=%h rdy=%b busy=%b required 0/00/0/1",
               bus.m_valid, bus.m_data, bus.req_ready, busy);
    end
    tests++;
    if (usrcclkts !== 1'b0 || fcsbts !== 1'b0) begin
      fails++;
      $display("FAIL reset_ts: usrcclkts=%b fcsbts=%b required 0/0", usrcclkts, fcsbts);
    end
    rst_n = 1'b1;
    p0 = prime_pulses;
    repeat (50) begin
      @(negedge clk);
      if (usrcclko !== 1'b0 || busy !== 1'b1 || bus.req_ready !== 1'b0) bad = 1;
    end
    tests++;
    if (bad || prime_pulses != p0) begin
      fails++;
      $display("FAIL pre_eos_quiet: activity=%b pulses=%0d required 0/0", bad, prime_pulses - p0);
    end
    eos = 1'b1;
    wait_ready_after_prime("eos_prime");
  endtask

  task automatic test_read();
    int p0 = cs_pulses, hi;
    do_req(24'h123456, 16'd2);
    drain(0, 0, hi);
    check_pulses("read_sck", cs_pulses - p0, 48);
    tests++;
    if (fl_shift !== 32'h03123456) begin
      fails++;
      $display("FAIL mosi_cmd_addr: mosi=%h required 03123456", fl_shift);
    end
    tests++;
    if (hi < 4) begin
      fails++;
      $display("FAIL cs_high_time: clks=%0d required >=4", hi);
    end
  endtask

  task automatic test_stall();
    int p0 = cs_pulses, hi;
    do_req(24'h123456, 16'd2);
    drain(40, 0, hi);
    check_pulses("stall_sck", cs_pulses - p0, 48);
  endtask

  task automatic test_zero_len();
    int p0 = cs_pulses;
    bit bad = 0;
    do_req(24'h000010, 16'd0);
    tests++;
    if (busy !== 1'b0 || bus.req_ready !== 1'b1) begin
      fails++;
      $display("FAIL zero_len_idle: busy=%b rdy=%b required 0/1", busy, bus.req_ready);
    end
    repeat (20) begin
      @(negedge clk);
      if (fcsbo !== 1'b1 || bus.m_valid !== 1'b0) bad = 1;
    end
    tests++;
    if (bad || cs_pulses != p0) begin
      fails++;
      $display("FAIL zero_len_quiet: activity=%b pulses=%0d required 0/0", bad, cs_pulses - p0);
    end
  endtask

  task automatic test_addr_ignore();
    int p0 = cs_pulses, hi, n = 0;
    do_req(24'h00ABCD, 16'd3);
    while (fl_bits < 16 && n < 500) begin @(negedge clk); n++; end
    bus.req_valid = 1'b1;
    bus.req_addr  = 24'hFFFFFF;
    bus.req_len   = 16'd5;
    repeat (2) @(negedge clk);
    bus.req_valid = 1'b0;
    drain(0, 0, hi);
    check_pulses("ignore_sck", cs_pulses - p0, 56);
    tests++;
    if (fl_shift !== 32'h0300ABCD) begin
      fails++;
      $display("FAIL ignore_addr: mosi=%h required 0300ABCD", fl_shift);
    end
  endtask

  task automatic test_back_to_back();
    int p0, hi;
    logic [23:0] a;
    logic [15:0] l;
    for (int t = 0; t < 3; t++) begin
      a  = 24'($urandom);
      l  = 16'($urandom_range(1, 4));
      p0 = cs_pulses;
      do_req(a, l);
      drain(0, 1, hi);
      check_pulses("b2b_sck", cs_pulses - p0, 32 + 8 * int'(l));
    end
  endtask

  task automatic test_reset_mid();
    int n = 0, p0, hi;
    do_req(24'h123456, 16'd2);
    while (fl_bits < 36 && n < 500) begin @(negedge clk); n++; end
    tests++;
    if (n >= 500) begin
      fails++;
      $display("FAIL reset_mid_wait: bits=%0d required 36", fl_bits);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if (fcsbo !== 1'b1 || usrcclko !== 1'b0 || bus.m_valid !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid_pins: cs=%b sck=%b mv=%b busy=%b required 1/0/0/1",
               fcsbo, usrcclko, bus.m_valid, busy);
    end
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_ready_after_prime("reset_mid_prime");
    p0 = cs_pulses;
    do_req(24'h123457, 16'd1);
    drain(0, 0, hi);
    check_pulses("post_reset_sck", cs_pulses - p0, 40);
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_len   = '0;
    bus.m_ready   = 1'b1;
    test_reset();
    test_read();
    test_stall();
    test_zero_len();
    test_addr_ignore();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
